// File: rtl/stack_monitor.sv
// stack_monitor: tracks the live depth of an attached stack and reports high-water mark,
// depth warning, sticky overflow/underflow faults and a level interrupt.
module stack_monitor #(
  parameter int DEPTH = 18,
  parameter int WARN  = 16
) (
  input  logic       clk,
  input  logic       resetq,
  input  logic       valid,
  input  logic [1:0] delta,
  input  logic       clr,
  input  logic       irq_ack,
  output logic [7:0] depth,
  output logic [7:0] hwm,
  output logic       warn,
  output logic       ovf,
  output logic       unf,
  output logic       irq
);
  localparam logic [7:0] CAP      = 8'(DEPTH + 1);
  localparam logic [7:0] WARN_LVL = 8'(WARN);
  localparam logic [0:0] IDLE     = 1'b0;
  localparam logic [0:0] PEND     = 1'b1;
  logic       arm_q;
  logic [7:0] depth_q, depth_d, hwm_q, hwm_d;
  logic       warn_q, ovf_q, ovf_d, unf_q, unf_d;
  logic [0:0] state_q, state_d;
  logic       push, pop, ovf_set, unf_set;
  // arm_q holds off counting until one clean edge has passed after reset release
  assign push    = arm_q & valid & delta[0] & ~delta[1];
  assign pop     = arm_q & valid & delta[0] & delta[1];
  assign ovf_set = push & (depth_q == CAP);
  assign unf_set = pop & (depth_q == 8'd0);
  always_comb begin
    depth_d = (push && depth_q < CAP) ? depth_q + 8'd1 :
              (pop && depth_q != 8'd0) ? depth_q - 8'd1 : depth_q;
    hwm_d   = (clr || depth_d > hwm_q) ? depth_d : hwm_q;
    ovf_d   = ovf_set | (ovf_q & ~clr);
    unf_d   = unf_set | (unf_q & ~clr);
    state_d = (ovf_set || unf_set) ? PEND : (irq_ack ? IDLE : state_q);
  end
  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      arm_q   <= 1'b0;
      depth_q <= 8'd0;
      hwm_q   <= 8'd0;
      warn_q  <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      arm_q   <= 1'b1;
      depth_q <= depth_d;
      hwm_q   <= hwm_d;
      warn_q  <= depth_d >= WARN_LVL;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      state_q <= state_d;
    end
  end
  assign depth = depth_q;
  assign hwm   = hwm_q;
  assign warn  = warn_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign irq   = state_q == PEND;
endmodule
